// File: rtl/instruction_loader_pkg.sv
// Shared MIPS definitions used by the program loader and the decode stage.
package instruction_loader_pkg;

    // Width of one byte on the debug-unit stream.
    localparam int BYTE_SIZE = 8;

    // Word that ends a program load; the decode stage uses the same constant.
    localparam logic [31:0] DEFAULT_HALT_INSTRUCTION = 32'h0000_0001;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Shift register that packs a big-endian byte stream into instruction words.
// The first byte of a word ends up in the MSB after WORD_SIZE_IN_BYTES shifts.
module word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clear,
    input  logic                                    shift,
    input  logic [BYTE_SIZE-1:0]                    byte_in,
    output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] word,
    output logic                                    full
);

    localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
    localparam int CNT_W  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_SIZE_IN_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [WORD_W-1:0] word_r;
    logic [CNT_W-1:0]  count_r;

    // Shift register: new byte enters the LSB, older bytes move toward the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= {WORD_W{1'b0}};
        end else if (clear) begin
            word_r <= {WORD_W{1'b0}};
        end else if (shift) begin
            word_r <= (word_r << BYTE_SIZE) | WORD_W'(byte_in);
        end
    end

    // Byte position counter; wraps after the last byte of a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (shift) begin
            count_r <= full ? {CNT_W{1'b0}} : (count_r + CNT_ONE);
        end
    end

    assign word = word_r;
    // High while the next accepted byte completes the word.
    assign full = (count_r == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Program loader: clears instruction memory, then assembles bytes from the
// debug unit into words and issues one write pulse per word until the HALT
// word has been written or the memory is full.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int MEM_SIZE_IN_WORDS  = 10,
    parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_INSTRUCTION =
        (WORD_SIZE_IN_BYTES*8)'(DEFAULT_HALT_INSTRUCTION)
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_start,
    input  logic                                      i_byte_valid,
    input  logic [7:0]                                i_byte,
    output logic                                      o_byte_ready,
    output logic                                      o_clear_mem,
    output logic                                      o_instruction_write,
    output logic [WORD_SIZE_IN_BYTES*8-1:0]           o_instruction,
    output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]    o_word_count,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic                                      o_overflow
);

    localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
    localparam int WC_W   = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);
    localparam logic [WC_W-1:0] WC_LIMIT  = WC_W'(MEM_SIZE_IN_WORDS);

    loader_state_t     state_r;
    loader_state_t     next_state_s;
    logic              byte_ready_r;
    logic              clear_mem_r;
    logic              write_r;
    logic              busy_r;
    logic              done_r;
    logic              overflow_r;
    logic [WC_W-1:0]   word_count_r;
    logic              accept_s;
    logic              asm_clear_s;
    logic              last_byte_s;
    logic [WORD_W-1:0] word_s;

    // Ready is only ever high in RECEIVE, so this is the byte handshake.
    assign accept_s    = i_byte_valid && byte_ready_r;
    // Assembly register and word counter are zeroed as CLEAR is entered.
    assign asm_clear_s = (next_state_s == ST_CLEAR);

    word_assembler #(
        .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES)
    ) u_word_assembler (
        .clk     (i_clk),
        .rst     (i_reset),
        .clear   (asm_clear_s),
        .shift   (accept_s),
        .byte_in (i_byte),
        .word    (word_s),
        .full    (last_byte_s)
    );

    // Next-state logic; HALT takes priority over the memory-full check.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) next_state_s = ST_CLEAR;
                else         next_state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                next_state_s = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (accept_s && last_byte_s) next_state_s = ST_WRITE;
                else                         next_state_s = ST_RECEIVE;
            end
            ST_WRITE: begin
                if (word_s == HALT_INSTRUCTION)                next_state_s = ST_DONE;
                else if ((word_count_r + WC_ONE) == WC_LIMIT)  next_state_s = ST_ERROR;
                else                                           next_state_s = ST_RECEIVE;
            end
            ST_DONE: begin
                if (i_start) next_state_s = ST_CLEAR;
                else         next_state_s = ST_DONE;
            end
            ST_ERROR: begin
                if (i_start) next_state_s = ST_CLEAR;
                else         next_state_s = ST_ERROR;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus outputs decoded from the next state so every
    // output comes straight from a flop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            byte_ready_r <= 1'b0;
            clear_mem_r  <= 1'b0;
            write_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            byte_ready_r <= (next_state_s == ST_RECEIVE);
            clear_mem_r  <= (next_state_s == ST_CLEAR);
            write_r      <= (next_state_s == ST_WRITE);
            busy_r       <= (next_state_s == ST_CLEAR) || (next_state_s == ST_RECEIVE) ||
                            (next_state_s == ST_WRITE);
            done_r       <= (next_state_s == ST_DONE);
            overflow_r   <= (next_state_s == ST_ERROR);
        end
    end

    // Words written in the current load; bumps at the end of each WRITE cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_count_r <= {WC_W{1'b0}};
        end else if (asm_clear_s) begin
            word_count_r <= {WC_W{1'b0}};
        end else if (state_r == ST_WRITE) begin
            word_count_r <= word_count_r + WC_ONE;
        end
    end

    assign o_byte_ready        = byte_ready_r;
    assign o_clear_mem         = clear_mem_r;
    assign o_instruction_write = write_r;
    assign o_instruction       = word_s;
    assign o_word_count        = word_count_r;
    assign o_busy              = busy_r;
    assign o_done              = done_r;
    assign o_overflow          = overflow_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a per-cycle vector table for the
// basic load / restart flow, then hand-written multi-cycle sequences.
module tb_instruction_loader;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_clear_mem;
    logic        o_instruction_write;
    logic [31:0] o_instruction;
    logic [3:0]  o_word_count;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    logic [31:0] got_q[$];

    instruction_loader #(
        .WORD_SIZE_IN_BYTES (4),
        .MEM_SIZE_IN_WORDS  (10),
        .HALT_INSTRUCTION   (32'h0000_0001)
    ) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_start             (i_start),
        .i_byte_valid        (i_byte_valid),
        .i_byte              (i_byte),
        .o_byte_ready        (o_byte_ready),
        .o_clear_mem         (o_clear_mem),
        .o_instruction_write (o_instruction_write),
        .o_instruction       (o_instruction),
        .o_word_count        (o_word_count),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_overflow          (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Capture every write pulse away from the active edge.
    always @(negedge i_clk) begin
        if (o_instruction_write === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            got_q.push_back(o_instruction);
        end
    end

    typedef struct {
        string       name;
        logic        start;
        logic        valid;
        logic [7:0]  b;
        logic        ready;
        logic        clear;
        logic        write;
        logic        busy;
        logic        done;
        logic        ovf;
        logic [3:0]  cnt;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [63:0] out_vec();
        return {22'd0, o_byte_ready, o_clear_mem, o_instruction_write, o_busy,
                o_done, o_overflow, o_word_count, o_instruction};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        i_byte_valid = 1'b0;
        repeat (gap) step();
        i_byte_valid = 1'b1;
        i_byte       = b;
        waited       = 0;
        while (o_byte_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        if (o_byte_ready !== 1'b1) begin
            check("byte_ready_timeout", 64'(o_byte_ready), 64'd1);
        end else begin
            step();
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[k*8 +: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        end
    endtask

    task automatic start_load(input string name);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check({name, "_clear"}, 64'({o_clear_mem, o_busy, o_word_count}), 64'({1'b1, 1'b1, 4'd0}));
        step();
        check({name, "_ready"}, 64'({o_byte_ready, o_clear_mem}), 64'({1'b1, 1'b0}));
    endtask

    task automatic check_words(input string name, input int base, input logic [31:0] exp_q[$]);
        check({name, "_nwrites"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < got_q.size())
                check({name, "_word"}, 64'(got_q[base + k]), 64'(exp_q[k]));
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w;
        int          base;
        logic        saw_ready;

        // name, start, valid, byte | ready clear write busy done ovf cnt instr
        vecs[0]  = '{"start",      1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_0000};
        vecs[1]  = '{"clear_byte", 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_0000};
        vecs[2]  = '{"b12",        1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_0012};
        vecs[3]  = '{"b34",        1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_1234};
        vecs[4]  = '{"b56",        1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0012_3456};
        vecs[5]  = '{"b78_write",  1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h1234_5678};
        vecs[6]  = '{"byte_in_wr", 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h1234_5678};
        vecs[7]  = '{"h0",         1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h3456_7800};
        vecs[8]  = '{"h1",         1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h5678_0000};
        vecs[9]  = '{"h2",         1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h7800_0000};
        vecs[10] = '{"h3_write",   1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0000_0001};
        vecs[11] = '{"done",       1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h0000_0001};
        vecs[12] = '{"done_hold",  1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h0000_0001};
        vecs[13] = '{"restart",    1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_0000};
        vecs[14] = '{"start_busy", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_0000};
        vecs[15] = '{"start_recv", 1'b1, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_00AB};

        i_reset      = 1'b1;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
        repeat (3) step();
        check("reset_state", out_vec(), 64'd0);
        i_reset = 1'b0;
        step();
        check("idle_state", out_vec(), 64'd0);

        // Basic load, byte offered in WRITE, restart from DONE, start ignored while busy.
        for (int i = 0; i < 16; i++) begin
            i_start      = vecs[i].start;
            i_byte_valid = vecs[i].valid;
            i_byte       = vecs[i].b;
            step();
            check(vecs[i].name, out_vec(),
                  64'({vecs[i].ready, vecs[i].clear, vecs[i].write, vecs[i].busy,
                       vecs[i].done, vecs[i].ovf, vecs[i].cnt, vecs[i].instr}));
        end
        i_start = 1'b0;
        exp_q   = '{32'h1234_5678, 32'h0000_0001};
        check_words("basic", 0, exp_q);

        // Reset after two bytes of a word: everything returns to zero, no write.
        i_byte_valid = 1'b1;
        i_byte       = 8'hCD;
        step();
        check("two_bytes", 64'(o_instruction), 64'h0000_ABCD);
        base    = wr_cnt;
        i_reset = 1'b1;
        #2;
        check("async_reset", out_vec(), 64'd0);
        repeat (3) step();
        i_reset = 1'b0;
        repeat (3) step();
        i_byte_valid = 1'b0;
        check("post_reset", out_vec(), 64'd0);
        check("reset_no_write", 64'(wr_cnt - base), 64'd0);

        // Gapped bytes, with a byte offered during WRITE that must be ignored.
        start_load("gap");
        base = got_q.size();
        send_word(32'hDEAD_BEEF, 20);
        i_byte_valid = 1'b1;
        i_byte       = 8'hEE;
        check("gap_wr_ready", 64'({o_instruction_write, o_byte_ready}), 64'({1'b1, 1'b0}));
        step();
        i_byte_valid = 1'b0;
        check("gap_wr_hold", 64'(o_instruction), 64'hDEAD_BEEF);
        send_word(32'hCAFE_F00D, 20);
        send_word(32'h0000_0001, 20);
        step();
        check("gap_done", 64'({o_done, o_overflow, o_word_count}), 64'({1'b1, 1'b0, 4'd3}));
        exp_q = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001};
        check_words("gap", base, exp_q);

        // Overflow: ten non-HALT words, then more bytes must not be written.
        start_load("ovf");
        base = got_q.size();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            if (w == 32'h0000_0001) w = 32'h0000_0002;
            exp_q.push_back(w);
            send_word(w, 0);
        end
        step();
        check("ovf_flags", 64'({o_done, o_overflow, o_busy, o_word_count}),
              64'({1'b0, 1'b1, 1'b0, 4'd10}));
        saw_ready    = 1'b0;
        i_byte_valid = 1'b1;
        i_byte       = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_byte_ready) saw_ready = 1'b1;
        end
        i_byte_valid = 1'b0;
        check("ovf_no_ready", 64'(saw_ready), 64'd0);
        check_words("ovf", base, exp_q);

        // HALT in the final slot ends in DONE, not ERROR.
        start_load("last");
        base = got_q.size();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            w = $urandom | 32'h0000_0100;
            exp_q.push_back(w);
            send_word(w, 0);
        end
        exp_q.push_back(32'h0000_0001);
        send_word(32'h0000_0001, 0);
        step();
        check("last_flags", 64'({o_done, o_overflow, o_word_count}), 64'({1'b1, 1'b0, 4'd10}));
        check_words("last", base, exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that feeds `instruction_memory` from a byte stream (debug unit / UART side) and drives that memory's write and clear interface. It clears the memory and assembles incoming bytes into big-endian instruction words. Each word is written with a one-cycle write pulse, and loading stops on the HALT word or when memory is full. Sits between the debug-unit byte source and the IF-stage instruction memory.

## Interface
Parameters:
- `WORD_SIZE_IN_BYTES`, 4, bytes per instruction word.
- `MEM_SIZE_IN_WORDS`, 10, instruction memory depth in words.
- `HALT_INSTRUCTION`, 32'h00000001, word that terminates a load; it is written to memory before stopping.

Ports:
- `i_clk`  in  1  clock. One clock domain.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  begin a new load. Sampled only in IDLE, DONE and ERROR.
- `i_byte_valid`  in  1  `i_byte` holds a valid byte.
- `i_byte`  in  8  program byte; the first byte of each word is the MSB.
- `o_byte_ready`  out  1  loader accepts a byte this cycle.
- `o_clear_mem`  out  1  one-cycle clear pulse to instruction memory.
- `o_instruction_write`  out  1  one-cycle write pulse to instruction memory.
- `o_instruction`  out  WORD_SIZE_IN_BYTES*8  assembled word.
- `o_word_count`  out  $clog2(MEM_SIZE_IN_WORDS+1)  words written in the current load.
- `o_busy`  out  1  high in CLEAR, RECEIVE and WRITE.
- `o_done`  out  1  HALT word written; held.
- `o_overflow`  out  1  memory filled without HALT; held.

## Operation
- States: IDLE, CLEAR, RECEIVE, WRITE, DONE, ERROR.
- IDLE → CLEAR on `i_start`.
- DONE and ERROR: stay until `i_start`, then → CLEAR. Leaving DONE or ERROR drops `o_done` or `o_overflow`.
- CLEAR:
  - `o_clear_mem`=1 for exactly 1 cycle.
  - Byte counter, assembly register and `o_word_count` are zeroed.
  - Next state RECEIVE.
- RECEIVE:
  - `o_byte_ready`=1.
  - A byte is accepted when `i_byte_valid && o_byte_ready`; the assembly register shifts left 8 and `i_byte` enters the LSB.
  - When byte WORD_SIZE_IN_BYTES is accepted → WRITE.
- WRITE:
  - `o_instruction_write`=1 for 1 cycle and `o_byte_ready`=0.
  - `o_instruction` holds the assembled word and stays stable until the next word's first byte is accepted.
  - `o_word_count` increments at the end of the cycle.
  - Next-state priority:
    - word == HALT_INSTRUCTION → DONE;
    - else count+1 == MEM_SIZE_IN_WORDS → ERROR;
    - else → RECEIVE.
- HALT in the last slot goes to DONE, not ERROR.
- `i_start` is ignored while `o_busy`=1; a load cannot be aborted except by `i_reset`.
- Write addressing is implicit: instruction memory advances its own write pointer on each write pulse, and the loader never exceeds MEM_SIZE_IN_WORDS pulses per load.
- Bytes presented outside RECEIVE are not accepted, because `o_byte_ready`=0.

## Timing
- Reset values: all outputs 0, state IDLE. `i_reset` mid-load aborts immediately with no further write or clear pulse; the memory contents are then undefined for the bench.
- `i_start` high in IDLE at edge N: `o_clear_mem` high during cycle N+1 and `o_byte_ready` high from N+2.
- Last byte of a word accepted at edge M: `o_instruction_write` high during cycle M+1, and `o_byte_ready` high again from M+2.
- Peak throughput: one word per WORD_SIZE_IN_BYTES+1 cycles.
- `o_done` or `o_overflow` rises the cycle after the final write pulse.
- All outputs are registered; there is no combinational path from inputs to outputs except none.

## Structure
- The shared MIPS package/header holds:
  - `BYTE_SIZE` (8);
  - the loader state encoding;
  - the default HALT_INSTRUCTION constant, shared with the decode stage.
- Natural sub-module: `word_assembler`, a shift register plus byte counter with `clear`, `shift` and `full` outputs.
- Top level holds the FSM, word counter and status flags.

## Test plan
- Basic load:
  - Stimulus: reset, `i_start`, then bytes 12 34 56 78 followed by the 4 bytes of 00000001.
  - Required: one `o_clear_mem` pulse, then write pulses carrying 12345678 and 00000001, `o_word_count`=2, `o_done`=1, `o_overflow`=0.
- Overflow:
  - Stimulus: 10 random non-HALT words.
  - Required: exactly 10 write pulses, `o_word_count`=10, `o_overflow`=1, and no 11th write pulse even if more bytes arrive.
- HALT in the last slot:
  - Stimulus: 9 random words followed by 00000001.
  - Required: `o_done`=1 and `o_overflow`=0.
- Gapped valid:
  - Stimulus: random 0–20-cycle gaps between bytes, plus `i_byte_valid` asserted during WRITE.
  - Required: the byte offered during WRITE is not accepted (ready low); assembled words match the sent bytes exactly.
- Restart and reset:
  - Stimulus: `i_start` pulsed mid-load.
  - Required: it is ignored.
  - Stimulus: `i_start` in DONE.
  - Required: a new clear pulse and `o_word_count`=0.
  - Stimulus: `i_reset` after 2 bytes.
  - Required: all outputs 0 and no write pulse.
